// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and the TX state encoding.
// Kept separate so the receive side can reuse the same constants.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_DATA,
    ST_START_BIT,
    ST_DATA_BITS,
    ST_STOP_BIT,
    ST_DONE
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick marks the last clock of each UART bit.
// The count restarts from zero whenever the enable drops.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk_tx_i,
  input  logic reset,
  input  logic en,
  output logic bit_tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_tx_i) begin
    if (reset || !en) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bit_tick = en && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// Pulls NUM_BYTES bytes from the FIFO read port and sends each as an 8N1 frame.
// state        | meaning
// ST_IDLE      | line high, waiting for start
// ST_REQ       | raise fifo_read
// ST_WAIT_DATA | hold fifo_read until fifo_rd_done, latch byte
// ST_START_BIT | line low for one bit period
// ST_DATA_BITS | shift out 8 data bits LSB first
// ST_STOP_BIT  | line high for one bit period, count byte
// ST_DONE      | one-cycle tx_done, back to idle
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_BYTES    = 8
) (
  input  logic       clk_tx_i,
  input  logic       reset,
  input  logic       start,
  input  logic       fifo_rd_done,
  input  logic [7:0] fifo_data_in,
  output logic       fifo_read,
  output logic       tx_o,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [7:0] LAST_BYTE = 8'(NUM_BYTES);
  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_state_e r_state;
  logic [7:0]  r_shift;
  logic [7:0]  r_byte_cnt;
  logic [2:0]  r_bit_idx;
  logic        r_fifo_read;
  logic        r_tx;
  logic        r_busy;
  logic        r_done;
  logic        w_baud_en;
  logic        w_bit_tick;
  logic [7:0]  w_byte_cnt_next;

  assign w_baud_en = (r_state == ST_START_BIT) || (r_state == ST_DATA_BITS) ||
                     (r_state == ST_STOP_BIT);
  assign w_byte_cnt_next = r_byte_cnt + 8'd1;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_tx_i(clk_tx_i),
    .reset   (reset),
    .en      (w_baud_en),
    .bit_tick(w_bit_tick)
  );

  always_ff @(posedge clk_tx_i) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_byte_cnt  <= '0;
      r_bit_idx   <= '0;
      r_fifo_read <= 1'b0;
      r_tx        <= UART_IDLE_LEVEL;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_byte_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_fifo_read <= 1'b1;
          r_state     <= ST_WAIT_DATA;
        end
        ST_WAIT_DATA: begin
          if (fifo_rd_done) begin
            r_shift     <= fifo_data_in;
            r_fifo_read <= 1'b0;
            r_tx        <= 1'b0;
            r_state     <= ST_START_BIT;
          end
        end
        ST_START_BIT: begin
          if (w_bit_tick) begin
            r_tx      <= r_shift[0];
            r_bit_idx <= '0;
            r_state   <= ST_DATA_BITS;
          end
        end
        ST_DATA_BITS: begin
          // line is registered, so the next bit is presented from shift[1]
          if (w_bit_tick) begin
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit_idx == LAST_BIT) begin
              r_tx    <= UART_IDLE_LEVEL;
              r_state <= ST_STOP_BIT;
            end else begin
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        ST_STOP_BIT: begin
          if (w_bit_tick) begin
            r_byte_cnt <= w_byte_cnt_next;
            if (w_byte_cnt_next == LAST_BYTE) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_read = r_fifo_read;
  assign tx_o      = r_tx;
  assign tx_busy   = r_busy;
  assign tx_done   = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: 8-byte instance with a FIFO model counting 0..7, plus a
// 1-byte instance answering 8'hA5 for the exact-waveform check.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic       stray0 = 1'b0;
  logic       m_done0 = 1'b0;
  logic       m_done1 = 1'b0;
  logic [7:0] m_data0 = 8'h00;
  logic [2:0] m_ptr0 = 3'd0;
  int         m_cnt0 = 0;
  int         m_cnt1 = 0;
  int         lat0 = 3;
  int         hs0 = 0;
  int         dn0 = 0;
  int         errors = 0;
  int         checks = 0;

  logic       fifo_rd_done0, fifo_read0, tx_o0, tx_busy0, tx_done0;
  logic [7:0] fifo_data0;
  logic       fifo_read1, tx_o1, tx_busy1, tx_done1;

  assign fifo_rd_done0 = m_done0 | stray0;
  assign fifo_data0    = stray0 ? 8'hFF : m_data0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(4), .NUM_BYTES(8)) u_dut0 (
    .clk_tx_i(clk), .reset(reset), .start(start0),
    .fifo_rd_done(fifo_rd_done0), .fifo_data_in(fifo_data0),
    .fifo_read(fifo_read0), .tx_o(tx_o0), .tx_busy(tx_busy0), .tx_done(tx_done0)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(4), .NUM_BYTES(1)) u_dut1 (
    .clk_tx_i(clk), .reset(reset), .start(start1),
    .fifo_rd_done(m_done1), .fifo_data_in(8'hA5),
    .fifo_read(fifo_read1), .tx_o(tx_o1), .tx_busy(tx_busy1), .tx_done(tx_done1)
  );

  // FIFO models: done on the lat-th cycle that fifo_read is seen high
  always @(negedge clk) begin
    if (reset) begin
      m_done0 = 1'b0; m_cnt0 = 0; m_ptr0 = 3'd0;
    end else if (m_done0) begin
      m_done0 = 1'b0; m_cnt0 = 0;
    end else if (fifo_read0) begin
      m_cnt0++;
      if (m_cnt0 >= lat0) begin
        m_done0 = 1'b1;
        m_data0 = {5'b0, m_ptr0};
        m_ptr0++;
        hs0++;
      end
    end
    if (tx_done0 === 1'b1) dn0++;
  end

  always @(negedge clk) begin
    if (reset) begin
      m_done1 = 1'b0; m_cnt1 = 0;
    end else if (m_done1) begin
      m_done1 = 1'b0; m_cnt1 = 0;
    end else if (fifo_read1) begin
      m_cnt1++;
      if (m_cnt1 >= 3) m_done1 = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  // Decodes one frame from dut0, mid-bit sampling; optionally pulses start mid-frame.
  task automatic recv_byte(input bit poke, output logic [7:0] b, output int gap, output bit ok);
    ok = 1'b1; gap = 0; b = 8'h00;
    while (tx_o0 !== 1'b0 && gap < 200) begin
      tick();
      gap++;
    end
    if (tx_o0 !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    tick(); tick();
    if (tx_o0 !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (4) tick();
      b[i] = tx_o0;
      if (poke && i == 3) begin
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
      end
    end
    repeat (4) tick();
    if (tx_o0 !== 1'b1) ok = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (tx_done0 === 1'b1) begin
        found = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (tx_o0 !== 1'b1 || fifo_read0 !== 1'b0 || tx_busy0 !== 1'b0 ||
          tx_o1 !== 1'b1 || fifo_read1 !== 1'b0 || tx_busy1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: tx=%b/%b rd=%b/%b busy=%b/%b, want tx=1 rd=0 busy=0",
                 i, tx_o0, tx_o1, fifo_read0, fifo_read1, tx_busy0, tx_busy1);
      end
    end
  endtask

  task automatic test_single_byte();
    logic [9:0] frame;
    int n;
    frame = {1'b1, 8'hA5, 1'b0};
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checks++;
    if (tx_busy1 !== 1'b1 || fifo_read1 !== 1'b0) begin
      errors++;
      $display("FAIL single_t1: busy=%b rd=%b, want busy=1 rd=0", tx_busy1, fifo_read1);
    end
    tick();
    checks++;
    if (fifo_read1 !== 1'b1) begin
      errors++;
      $display("FAIL single_t2_read: got %b want 1", fifo_read1);
    end
    n = 0;
    while (tx_o1 !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (tx_o1 !== 1'b0 || fifo_read1 !== 1'b0) begin
      errors++;
      $display("FAIL single_start_edge: tx=%b rd=%b, want tx=0 rd=0", tx_o1, fifo_read1);
    end
    for (int j = 0; j < 40; j++) begin
      checks++;
      if (tx_o1 !== frame[j/4]) begin
        errors++;
        $display("FAIL single_bit cycle %0d: got %b want %b", j, tx_o1, frame[j/4]);
      end
      tick();
    end
    checks++;
    if (tx_done1 !== 1'b1 || tx_busy1 !== 1'b0) begin
      errors++;
      $display("FAIL single_done: done=%b busy=%b, want done=1 busy=0", tx_done1, tx_busy1);
    end
    tick();
    checks++;
    if (tx_done1 !== 1'b0 || tx_busy1 !== 1'b0 || tx_o1 !== 1'b1) begin
      errors++;
      $display("FAIL single_after: done=%b busy=%b tx=%b, want 0 0 1", tx_done1, tx_busy1, tx_o1);
    end
  endtask

  task automatic test_burst();
    logic [7:0] b;
    int gap, hs, dn;
    bit ok, found;
    stray0 = 1'b1;
    tick();
    stray0 = 1'b0;
    tick();
    checks++;
    if (tx_busy0 !== 1'b0 || fifo_read0 !== 1'b0) begin
      errors++;
      $display("FAIL stray_done: busy=%b rd=%b, want 0 0", tx_busy0, fifo_read0);
    end
    hs = hs0; dn = dn0;
    pulse_start0();
    checks++;
    if (tx_busy0 !== 1'b1) begin
      errors++;
      $display("FAIL burst_busy_rise: got %b want 1", tx_busy0);
    end
    tick();
    checks++;
    if (fifo_read0 !== 1'b1) begin
      errors++;
      $display("FAIL burst_read_rise: got %b want 1", fifo_read0);
    end
    for (int k = 0; k < 8; k++) begin
      recv_byte(1'b0, b, gap, ok);
      checks++;
      if (!ok || b !== 8'(k)) begin
        errors++;
        $display("FAIL burst_frame %0d: got %02h framing_ok=%b want %02h", k, b, ok, k);
      end
      if (k > 0) begin
        checks++;
        if (gap !== 6) begin
          errors++;
          $display("FAIL burst_gap %0d: got %0d want 6", k, gap);
        end
      end
    end
    wait_done(10, found);
    checks++;
    if (!found || tx_busy0 !== 1'b0) begin
      errors++;
      $display("FAIL burst_done: found=%b busy=%b, want 1 0", found, tx_busy0);
    end
    tick();
    checks++;
    if (tx_done0 !== 1'b0) begin
      errors++;
      $display("FAIL burst_done_width: got %b want 0", tx_done0);
    end
    checks++;
    if (hs0 - hs !== 8 || dn0 - dn !== 1) begin
      errors++;
      $display("FAIL burst_counts: handshakes=%0d dones=%0d, want 8 1", hs0 - hs, dn0 - dn);
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] b;
    int gap, hs, dn, bad;
    bit ok, found;
    hs = hs0; dn = dn0;
    pulse_start0();
    for (int k = 0; k < 8; k++) begin
      recv_byte(k == 1, b, gap, ok);
      checks++;
      if (!ok || b !== 8'(k)) begin
        errors++;
        $display("FAIL ignore_frame %0d: got %02h framing_ok=%b want %02h", k, b, ok, k);
      end
    end
    wait_done(10, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL ignore_done: tx_done not seen, want pulse");
    end
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (fifo_read0 !== 1'b0 || tx_busy0 !== 1'b0 || tx_o0 !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL ignore_done_start: %0d busy cycles, want 0", bad);
    end
    checks++;
    if (hs0 - hs !== 8 || dn0 - dn !== 1) begin
      errors++;
      $display("FAIL ignore_counts: handshakes=%0d dones=%0d, want 8 1", hs0 - hs, dn0 - dn);
    end
  endtask

  task automatic test_slow_fifo();
    int n, bad;
    bit found;
    lat0 = 21;
    pulse_start0();
    tick();
    n = 0; bad = 0;
    while (m_done0 !== 1'b1 && n < 100) begin
      if (fifo_read0 !== 1'b1 || tx_o0 !== 1'b1) bad++;
      tick();
      n++;
    end
    checks++;
    if (n !== 20 || bad !== 0) begin
      errors++;
      $display("FAIL slow_wait: cycles=%0d bad=%0d, want 20 0", n, bad);
    end
    checks++;
    if (fifo_read0 !== 1'b1 || tx_o0 !== 1'b1) begin
      errors++;
      $display("FAIL slow_done_cycle: rd=%b tx=%b, want 1 1", fifo_read0, tx_o0);
    end
    lat0 = 3;
    tick();
    checks++;
    if (fifo_read0 !== 1'b0 || tx_o0 !== 1'b0) begin
      errors++;
      $display("FAIL slow_start_bit: rd=%b tx=%b, want 0 0", fifo_read0, tx_o0);
    end
    wait_done(1000, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL slow_done: tx_done not seen, want pulse");
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    int gap, n, dn, bad;
    bit ok, found;
    pulse_start0();
    recv_byte(1'b0, b, gap, ok);
    recv_byte(1'b0, b, gap, ok);
    n = 0;
    while (tx_o0 !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    repeat (17) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (tx_o0 !== 1'b1 || tx_busy0 !== 1'b0 || fifo_read0 !== 1'b0) begin
      errors++;
      $display("FAIL midreset: tx=%b busy=%b rd=%b, want 1 0 0", tx_o0, tx_busy0, fifo_read0);
    end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_o0 !== 1'b1 || tx_busy0 !== 1'b0 || fifo_read0 !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL midreset_quiet: %0d active cycles, want 0", bad);
    end
    dn = dn0;
    pulse_start0();
    for (int k = 0; k < 8; k++) begin
      recv_byte(1'b0, b, gap, ok);
      checks++;
      if (!ok || b !== 8'(k)) begin
        errors++;
        $display("FAIL restart_frame %0d: got %02h framing_ok=%b want %02h", k, b, ok, k);
      end
      if (k == 6) begin
        checks++;
        if (dn0 - dn !== 0) begin
          errors++;
          $display("FAIL restart_early_done: dones=%0d want 0", dn0 - dn);
        end
      end
    end
    wait_done(10, found);
    tick();
    checks++;
    if (!found || dn0 - dn !== 1) begin
      errors++;
      $display("FAIL restart_done: found=%b dones=%0d, want 1 1", found, dn0 - dn);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_start_ignored();
    test_slow_fifo();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
